// File: rtl/hsst_pkg.sv
// Shared constants for the HSST transmit scheduler: lane control words,
// K-flag patterns, FSM state encoding and the payload-length clamp.
package hsst_pkg;

   typedef logic [2:0] hsst_state_t;

   localparam hsst_state_t S_IDLE = 3'd0;
   localparam hsst_state_t S_PRE  = 3'd1;
   localparam hsst_state_t S_SOF  = 3'd2;
   localparam hsst_state_t S_DATA = 3'd3;
   localparam hsst_state_t S_CHK  = 3'd4;
   localparam hsst_state_t S_EOF  = 3'd5;
   localparam hsst_state_t S_GAP  = 3'd6;

   localparam logic [31:0] K_IDLE      = 32'hff_00_00_bc;
   localparam logic [7:0]  K_SOF_CHAR  = 8'h5C;
   localparam logic [31:0] K_EOF       = 32'h0000_00FD;
   localparam logic [3:0]  K_FLAG_CTRL = 4'b0001;
   localparam logic [3:0]  K_FLAG_DATA = 4'b0000;

   function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                             input logic [15:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/hsst_tx_sched_if.sv
// Source-side handshake, FIFO read port and HSST lane output of the scheduler.
// master = scheduler, slave = frame sources / lane consumer.
interface hsst_tx_sched_if;
   logic [1:0]  req;
   logic [15:0] len0;
   logic [15:0] len1;
   logic [1:0]  ack;
   logic [1:0]  rd_en;
   logic [31:0] rd_data0;
   logic [31:0] rd_data1;
   logic [1:0]  done;
   logic        busy;
   logic [31:0] hsst_txd;
   logic [3:0]  hsst_txk;

   modport master (
      input  req, len0, len1, rd_data0, rd_data1,
      output ack, rd_en, done, busy, hsst_txd, hsst_txk
   );

   modport slave (
      output req, len0, len1, rd_data0, rd_data1,
      input  ack, rd_en, done, busy, hsst_txd, hsst_txk
   );
endinterface

// File: rtl/hsst_rr_arb.sv
// Two-requester round-robin arbiter; on a tie the channel not granted last wins.
module hsst_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   // prio_q = 1 means ch1 is preferred on the next tie
   logic prio_q, prio_d;

   always_comb begin
      gnt    = 2'b00;
      prio_d = prio_q;
      if (en) begin
         if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
         else              gnt = req;
         if (gnt != 2'b00) prio_d = gnt[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end

endmodule

// File: rtl/hsst_tx_sched.sv
// HSST transmit scheduler: arbitrates two frame sources and serialises
// IDLE/SOF/payload/EOF words onto one lane. HSST_TX_CHKSUM_EN adds an XOR check word.
//
// state  | meaning
// S_IDLE | lane idles, arbitrate pending requests
// S_PRE  | first FIFO read in flight, lane idles
// S_SOF  | start-of-frame header (length, source id)
// S_DATA | N payload words from the granted FIFO
// S_CHK  | XOR of the payload (HSST_TX_CHKSUM_EN only)
// S_EOF  | end-of-frame control word, done pulse
// S_GAP  | IDLE_GAP idle words before the next arbitration
module hsst_tx_sched
   import hsst_pkg::*;
#(
   parameter int MAX_WORDS = 128,
   parameter int IDLE_GAP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   hsst_tx_sched_if.master  bus
);

   hsst_state_t state_q, state_d;
   logic [15:0] len_q, len_d;
   logic        src_q, src_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [8:0]  rd_left_q, rd_left_d;
   logic [1:0]  rd_en_q, rd_en_d;
   logic [1:0]  ack_q, ack_d;
   logic [1:0]  done_q, done_d;
   logic [31:0] data_q, data_d;
   logic [31:0] txd_q, txd_d;
   logic [3:0]  txk_q, txk_d;
`ifdef HSST_TX_CHKSUM_EN
   logic [31:0] chk_q, chk_d;
`endif

   logic [1:0]  gnt;
   logic        gnt_en;
   logic [15:0] len_grant;

   // ack_q blocks a re-grant in the cycle after a zero-length ack
   assign gnt_en    = (state_q == S_IDLE) && (ack_q == 2'b00);
   assign len_grant = clamp_len(gnt[1] ? bus.len1 : bus.len0, 16'(MAX_WORDS));

   hsst_rr_arb u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bus.req),
      .en    (gnt_en),
      .gnt   (gnt)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      rd_left_d = rd_left_q;
      rd_en_d   = rd_en_q;
      ack_d     = 2'b00;
      done_d    = 2'b00;
      // FIFO data is restaged one cycle so payload lands right after SOF
      data_d    = src_q ? bus.rd_data1 : bus.rd_data0;
      txd_d     = K_IDLE;
      txk_d     = K_FLAG_CTRL;
`ifdef HSST_TX_CHKSUM_EN
      chk_d     = chk_q;
`endif

      if (rd_en_q != 2'b00) begin
         if (rd_left_q == 9'd0) rd_en_d   = 2'b00;
         else                   rd_left_d = rd_left_q - 9'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (gnt != 2'b00) begin
               ack_d = gnt;
               src_d = gnt[1];
               len_d = len_grant;
`ifdef HSST_TX_CHKSUM_EN
               chk_d = 32'h0;
`endif
               if (len_grant == 16'd0) begin
                  done_d = gnt;
               end else begin
                  state_d   = S_PRE;
                  rd_en_d   = gnt;
                  rd_left_d = len_grant[8:0] - 9'd1;
               end
            end
         end
         S_PRE: state_d = S_SOF;
         S_SOF: begin
            txd_d   = {len_q, 7'd0, src_q, K_SOF_CHAR};
            cnt_d   = len_q[8:0] - 9'd1;
            state_d = S_DATA;
         end
         S_DATA: begin
            txd_d = data_q;
            txk_d = K_FLAG_DATA;
`ifdef HSST_TX_CHKSUM_EN
            chk_d = chk_q ^ data_q;
`endif
            if (cnt_q == 9'd0) begin
`ifdef HSST_TX_CHKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_EOF;
`endif
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
`ifdef HSST_TX_CHKSUM_EN
         S_CHK: begin
            txd_d   = chk_q;
            txk_d   = K_FLAG_DATA;
            state_d = S_EOF;
         end
`endif
         S_EOF: begin
            txd_d   = K_EOF;
            done_d  = src_q ? 2'b10 : 2'b01;
            cnt_d   = 9'(IDLE_GAP - 1);
            state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == 9'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 9'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         len_q     <= 16'd0;
         src_q     <= 1'b0;
         cnt_q     <= 9'd0;
         rd_left_q <= 9'd0;
         rd_en_q   <= 2'b00;
         ack_q     <= 2'b00;
         done_q    <= 2'b00;
         data_q    <= 32'h0;
         txd_q     <= K_IDLE;
         txk_q     <= K_FLAG_CTRL;
`ifdef HSST_TX_CHKSUM_EN
         chk_q     <= 32'h0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         src_q     <= src_d;
         cnt_q     <= cnt_d;
         rd_left_q <= rd_left_d;
         rd_en_q   <= rd_en_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         data_q    <= data_d;
         txd_q     <= txd_d;
         txk_q     <= txk_d;
`ifdef HSST_TX_CHKSUM_EN
         chk_q     <= chk_d;
`endif
      end
   end

   assign bus.ack      = ack_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.hsst_txd = txd_q;
   assign bus.hsst_txk = txk_q;

endmodule

// File: tb/tb_hsst_tx_sched.sv
// Directed bench for hsst_tx_sched: single frame, round-robin ties, zero length,
// clamping, optional checksum word and mid-frame reset.
module tb_hsst_tx_sched;

   localparam int MAXW = 128;
   localparam int GAP  = 4;
   localparam logic [31:0] IDLE_W = 32'hff0000bc;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hsst_tx_sched_if bus_if ();

   hsst_tx_sched #(.MAX_WORDS(MAXW), .IDLE_GAP(GAP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // FIFO model: data valid the cycle after rd_en
   logic [31:0] mem0 [1024];
   logic [31:0] mem1 [1024];
   int idx0 = 0, idx1 = 0, rdcnt0 = 0, rdcnt1 = 0;

   always @(posedge clk) begin
      if (bus_if.rd_en[0]) begin
         bus_if.rd_data0 <= mem0[idx0];
         idx0            <= (idx0 + 1) % 1024;
         rdcnt0          <= rdcnt0 + 1;
      end
      if (bus_if.rd_en[1]) begin
         bus_if.rd_data1 <= mem1[idx1];
         idx1            <= (idx1 + 1) % 1024;
         rdcnt1          <= rdcnt1 + 1;
      end
   end

   int checks = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_ack();
      int t = 0;
      @(negedge clk);
      while (bus_if.ack == 2'b00 && t < 400) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic do_frame(input int ch, input int n, input logic [15:0] lf,
                           output logic [31:0] chk_word);
      logic [1:0]  oh;
      logic [31:0] w, x;
      int b_idx, b_rd, b_oth;
      oh = (ch == 1) ? 2'b10 : 2'b01;
      wait_ack();
      check("ack", bus_if.ack, oh);
      check("busy_pre", bus_if.busy, 1'b1);
      b_idx = (ch == 1) ? idx1 : idx0;
      b_rd  = (ch == 1) ? rdcnt1 : rdcnt0;
      b_oth = (ch == 1) ? rdcnt0 : rdcnt1;
      bus_if.req[ch] = 1'b0;
      repeat (2) @(negedge clk);
      check("sof", {bus_if.hsst_txk, bus_if.hsst_txd},
            {4'b0001, lf, 7'd0, (ch == 1), 8'h5C});
      x = 32'h0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         w = (ch == 1) ? mem1[(b_idx + k) % 1024] : mem0[(b_idx + k) % 1024];
         x = x ^ w;
         check("data", {bus_if.hsst_txk, bus_if.hsst_txd}, {4'b0000, w});
      end
      chk_word = x;
`ifdef HSST_TX_CHKSUM_EN
      @(negedge clk);
      check("chk", {bus_if.hsst_txk, bus_if.hsst_txd}, {4'b0000, x});
      chk_word = bus_if.hsst_txd;
`endif
      @(negedge clk);
      check("eof", {bus_if.hsst_txk, bus_if.hsst_txd}, {4'b0001, 32'h000000FD});
      check("done", bus_if.done, oh);
      for (int g = 0; g < GAP; g++) begin
         @(negedge clk);
         check("gap", {bus_if.done, bus_if.hsst_txk, bus_if.hsst_txd},
               {2'b00, 4'b0001, IDLE_W});
      end
      check("gap_busy", bus_if.busy, 1'b0);
      check("rd_cnt", ((ch == 1) ? rdcnt1 : rdcnt0) - b_rd, n);
      check("rd_other", (ch == 1) ? rdcnt0 : rdcnt1, b_oth);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cw;
      int b;
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = 32'(i + 1);
         mem1[i] = 32'h1000_0000 + 32'(i);
      end
      bus_if.req  = 2'b00;
      bus_if.len0 = 16'd0;
      bus_if.len1 = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_lane", {bus_if.hsst_txk, bus_if.hsst_txd}, {4'b0001, IDLE_W});
      check("rst_outs", {bus_if.ack, bus_if.rd_en, bus_if.done, bus_if.busy}, 7'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // single frame, data 1..4
      bus_if.len0 = 16'd4;
      bus_if.req  = 2'b01;
      do_frame(0, 4, 16'h0004, cw);

      // ties from reset: ch0, ch1, then ch0 again
      rst_n = 1'b0;
      @(negedge clk);
      check("rst2_busy", bus_if.busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      bus_if.len0 = 16'd2;
      bus_if.len1 = 16'd3;
      bus_if.req  = 2'b11;
      do_frame(0, 2, 16'h0002, cw);
      do_frame(1, 3, 16'h0003, cw);
      bus_if.req = 2'b11;
      do_frame(0, 2, 16'h0002, cw);
      do_frame(1, 3, 16'h0003, cw);

      // zero-length request on ch1
      bus_if.len1 = 16'd0;
      bus_if.req  = 2'b10;
      wait_ack();
      check("z_ack", bus_if.ack, 2'b10);
      check("z_done", bus_if.done, 2'b10);
      check("z_rd", bus_if.rd_en, 2'b00);
      bus_if.req = 2'b00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("z_idle", {bus_if.rd_en, bus_if.busy, bus_if.hsst_txk, bus_if.hsst_txd},
               {2'b00, 1'b0, 4'b0001, IDLE_W});
      end

      // clamp 300 -> 128
      bus_if.len0 = 16'd300;
      bus_if.req  = 2'b01;
      do_frame(0, 128, 16'h0080, cw);

`ifdef HSST_TX_CHKSUM_EN
      mem0[idx0]              = 32'hA5A5A5A5;
      mem0[(idx0 + 1) % 1024] = 32'h0F0F0F0F;
      bus_if.len0 = 16'd2;
      bus_if.req  = 2'b01;
      do_frame(0, 2, 16'h0002, cw);
      check("chk_word", cw, 32'hAAAAAAAA);
`endif

      // reset while data word 3 is on the lane
      bus_if.len0 = 16'd8;
      bus_if.req  = 2'b01;
      wait_ack();
      check("r_ack", bus_if.ack, 2'b01);
      b = idx0;
      bus_if.req = 2'b00;
      repeat (2) @(negedge clk);
      check("r_sof", {bus_if.hsst_txk, bus_if.hsst_txd}, {4'b0001, 16'h0008, 8'h00, 8'h5C});
      repeat (3) @(negedge clk);
      check("r_d3", bus_if.hsst_txd, mem0[(b + 2) % 1024]);
      rst_n = 1'b0;
      @(negedge clk);
      check("r_after", {bus_if.rd_en, bus_if.done, bus_if.busy, bus_if.hsst_txk, bus_if.hsst_txd},
            {2'b00, 2'b00, 1'b0, 4'b0001, IDLE_W});
      @(negedge clk);
      check("r_nodone", bus_if.done, 2'b00);
      rst_n = 1'b1;
      @(negedge clk);
      bus_if.len0 = 16'd3;
      bus_if.req  = 2'b01;
      do_frame(0, 3, 16'h0003, cw);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/hsst_tx_sched.md
HSST_TX_SCHED -- requirements
Module: hsst_tx_sched

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 128, max payload words per frame (1..511).
REQ-002 SHALL have parameter IDLE_GAP, default 4, minimum idle words between frames (1..15).
REQ-003 SHALL have port clk  input  1  single clock for all logic; rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req  input  2  per-source frame request, level, held until ack.
REQ-005 SHALL have ports len0, len1  input  16 each  payload word count of the source, sampled at grant.
REQ-006 SHALL have port ack  output  2  one-cycle grant pulse per source.
REQ-007 SHALL have port rd_en  output  2  per-source FIFO read enable.
REQ-008 SHALL have ports rd_data0, rd_data1  input  32 each  FIFO read data, valid the cycle after rd_en.
REQ-009 SHALL have port done  output  2  one-cycle pulse in the EOF cycle of the granted source.
REQ-010 SHALL have port busy  output  1  high in every state except S_IDLE.
REQ-011 SHALL have ports hsst_txd  output  32  and hsst_txk  output  4  registered HSST lane word and K flags.

Function
REQ-012 SHALL use states S_IDLE, S_PRE, S_SOF, S_DATA, S_CHK, S_EOF, S_GAP.
REQ-013 S_IDLE/S_PRE/S_GAP SHALL drive IDLE word 32'hff_00_00_bc with k 4'b0001.
REQ-014 In S_IDLE with any req high, SHALL grant round-robin: the requester not granted last wins ties; after reset ch0 wins a tie.
REQ-015 On grant, SHALL pulse ack for one cycle, latch clamped length, and enter S_PRE.
REQ-016 Length 0 SHALL produce ack and done in the same cycle, no frame, no rd_en, and a return to S_IDLE.
REQ-017 Length above MAX_WORDS SHALL be clamped to MAX_WORDS.
REQ-018 rd_en of the granted source SHALL be high for exactly N consecutive cycles, starting in S_PRE.
REQ-019 S_SOF (1 cycle) SHALL drive {len[15:0], 7'd0, src_id, 8'h5C} with k 4'b0001.
REQ-020 S_DATA SHALL drive N words, k 4'b0000, in FIFO order with no bubbles; the first word is in the cycle after SOF.
REQ-021 S_EOF (1 cycle) SHALL drive 32'h0000_00FD with k 4'b0001 and pulse done.
REQ-022 S_GAP SHALL last exactly IDLE_GAP cycles, then return to S_IDLE.
REQ-023 The first SOF SHALL appear 2 cycles after the grant edge.
REQ-024 Frame length SHALL be N+2 words (+1 with checksum).
REQ-025 req changes during a frame SHALL be ignored until S_IDLE.
REQ-026 The non-granted rd_en SHALL stay 0.

Reset
REQ-027 On rst_n low, SHALL enter S_IDLE immediately with hsst_txd=32'hff_00_00_bc, hsst_txk=4'b0001, ack=0, rd_en=0, done=0, busy=0, and the round-robin pointer at ch0.
REQ-028 Reset mid-frame SHALL abandon the frame with no EOF and no done.

Configuration
REQ-029 With HSST_TX_CHKSUM_EN defined, S_CHK (1 cycle, k 4'b0000) SHALL sit between S_DATA and S_EOF and drive the XOR of all N payload words.
REQ-030 Without HSST_TX_CHKSUM_EN, S_CHK SHALL be unreachable and its logic absent; S_DATA SHALL go to S_EOF.

Structure
REQ-031 The shared package hsst_pkg SHALL hold K_IDLE (ff_00_00_bc), K_SOF_CHAR (5C), K_EOF (0000_00FD), the K-flag constants and the state encoding.
REQ-032 The round-robin arbiter SHALL be the sub-module hsst_rr_arb (2 requesters, grant and pointer update).

Verification
REQ-033 The bench SHALL cover: req=01, len0=4, data 1..4 -> ack[0], SOF 0004_005C, data 1,2,3,4, EOF, done[0], 4 idles.
REQ-034 The bench SHALL cover: req=11 from reset -> ch0 framed first, then ch1 after the gap; a second tie after that -> ch0 again.
REQ-035 The bench SHALL cover: len1=0 -> ack[1] and done[1] in the same cycle, no SOF, rd_en stays 0.
REQ-036 The bench SHALL cover: len0=300, MAX_WORDS=128 -> SOF length field 0080, 128 data words, rd_en high for 128 cycles.
REQ-037 The bench SHALL cover: with HSST_TX_CHKSUM_EN, data A5A5A5A5 and 0F0F0F0F -> check word AAAAAAAA before EOF.
REQ-038 The bench SHALL cover: rst_n low at data word 3 -> next cycle IDLE word, rd_en=0, no done; a new req is granted normally after release.
